// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, instruction register field positions and issue FSM states
package isa_pkg;
   localparam logic [4:0] MOVSGPR  = 5'b00000;
   localparam logic [4:0] MOV      = 5'b00001;
   localparam logic [4:0] ADD      = 5'b00010;
   localparam logic [4:0] SUB      = 5'b00011;
   localparam logic [4:0] MUL      = 5'b00100;
   localparam logic [4:0] DIV      = 5'b00101;
   localparam logic [4:0] OPC_HALT = 5'b11111;
   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 27;
   localparam int RDST_MSB  = 26;
   localparam int RDST_LSB  = 22;
   localparam int RSRC1_MSB = 21;
   localparam int RSRC1_LSB = 17;
   localparam int IMM_MODE  = 16;
   localparam int RSRC2_MSB = 15;
   localparam int RSRC2_LSB = 11;
   localparam int ISRC_MSB  = 15;
   localparam int ISRC_LSB  = 0;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_HALTED
   } issue_state_t;
endpackage

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: fetches words from a synchronous instruction memory and
// issues them to the execute stage over valid/ready until HALT or stop.
module instr_issue_unit
   import isa_pkg::*;
#(
   parameter int PC_WIDTH  = 5,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  start_pc,
   input  logic                 stop_req,
   output logic                 imem_rd_en,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          ir_out,
   output logic                 ir_valid,
   input  logic                 ir_ready,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 busy,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_count
);
   issue_state_t state;
   assign imem_rd_en = state == S_FETCH;
   assign imem_addr  = pc;
   assign ir_valid   = state == S_ISSUE;
   assign busy       = state == S_FETCH || state == S_WAIT || state == S_ISSUE;
   assign halted     = state == S_HALTED;
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir_out      <= '0;
         instr_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: if (start) begin
               pc          <= start_pc;
               instr_count <= '0;
               state       <= S_FETCH;
            end
            S_FETCH: state <= S_WAIT;
            // HALT is consumed here and never reaches the execute stage
            S_WAIT: if (imem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) state <= S_HALTED;
            else begin
               ir_out <= imem_rdata;
               state  <= S_ISSUE;
            end
            S_ISSUE: if (ir_ready) begin
               pc          <= pc + 1'b1;
               instr_count <= &instr_count ? instr_count : instr_count + 1'b1;
               state       <= stop_req ? S_IDLE : S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: scoreboard bench; expected issued words are queued at
// start and popped on every observed handshake.
module tb_instr_issue_unit;
   logic        clk = 0;
   logic        sys_rst = 1;
   logic        start = 0;
   logic [4:0]  start_pc = 0;
   logic        stop_req = 0;
   logic        imem_rd_en;
   logic [4:0]  imem_addr;
   logic [31:0] imem_rdata = 0;
   logic [31:0] ir_out;
   logic        ir_valid;
   logic        ir_ready = 0;
   logic [4:0]  pc;
   logic        busy;
   logic        halted;
   logic [15:0] instr_count;
   logic [31:0] mem [32];
   logic [31:0] exp_q [$];
   int checks = 0;
   int failures = 0;

   instr_issue_unit dut (
      .clk(clk), .sys_rst(sys_rst), .start(start), .start_pc(start_pc),
      .stop_req(stop_req), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .ir_out(ir_out), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .pc(pc), .busy(busy), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!sys_rst && ir_valid && ir_ready) begin
         chk("sb_depth", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("sb_issue", ir_out, exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [4:0] spc);
      start_pc = spc;
      start = 1;
      step();
      start = 0;
   endtask

   task automatic wait_halted();
      int n = 0;
      while (!halted && n < 50) begin
         step();
         n++;
      end
      chk("halt_timeout", 32'(halted), 1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0800_0000 | i;
      mem[0] = 32'h1082_0000;
      mem[1] = 32'h1946_0000;
      mem[2] = 32'hF800_0000;
      mem[3] = 32'h2800_0000;
      mem[5] = 32'h2000_1234;
      mem[6] = 32'hF800_0000;
      mem[31] = 32'h08C4_0000;
      step();
      step();
      chk("rst_ir_valid", 32'(ir_valid), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ir_out", ir_out, 0);
      chk("rst_count", 32'(instr_count), 0);
      chk("rst_flags", {imem_rd_en, busy, halted}, 0);
      sys_rst = 0;
      step();
      // basic program: ADD, SUB, HALT
      ir_ready = 1;
      exp_q.push_back(mem[0]);
      exp_q.push_back(mem[1]);
      kick(0);
      chk("t1_fetch_en", 32'(imem_rd_en), 1);
      chk("t1_fetch_addr", 32'(imem_addr), 0);
      step();
      chk("t1_wait_valid", 32'(ir_valid), 0);
      step();
      chk("t1_issue_valid", 32'(ir_valid), 1);
      chk("t1_issue_word", ir_out, 32'h1082_0000);
      wait_halted();
      chk("t1_pc", 32'(pc), 2);
      chk("t1_count", 32'(instr_count), 2);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_ir_keep", ir_out, 32'h1946_0000);
      chk("t1_sb_left", exp_q.size(), 0);
      // restart from HALTED at 5 with a stall
      ir_ready = 0;
      exp_q.push_back(mem[5]);
      kick(5);
      chk("t2_count_clr", 32'(instr_count), 0);
      chk("t2_fetch_addr", 32'(imem_addr), 5);
      chk("t2_fetch_en", 32'(imem_rd_en), 1);
      chk("t2_halted", 32'(halted), 0);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_valid", 32'(ir_valid), 1);
         chk("t2_stall_word", ir_out, 32'h2000_1234);
         chk("t2_stall_pc", 32'(pc), 5);
         chk("t2_stall_rd", 32'(imem_rd_en), 0);
         step();
      end
      ir_ready = 1;
      step();
      chk("t2_pc_inc", 32'(pc), 6);
      chk("t2_count", 32'(instr_count), 1);
      wait_halted();
      chk("t2_sb_left", exp_q.size(), 0);
      // pc wrap from 31
      exp_q.push_back(mem[31]);
      exp_q.push_back(mem[0]);
      exp_q.push_back(mem[1]);
      kick(31);
      chk("t3_fetch_addr", 32'(imem_addr), 31);
      step();
      step();
      step();
      chk("t3_wrap_pc", 32'(pc), 0);
      chk("t3_wrap_addr", 32'(imem_addr), 0);
      chk("t3_wrap_fetch", 32'(imem_rd_en), 1);
      wait_halted();
      chk("t3_pc", 32'(pc), 2);
      chk("t3_count", 32'(instr_count), 3);
      chk("t3_sb_left", exp_q.size(), 0);
      // stop_req raised during WAIT
      exp_q.push_back(mem[0]);
      kick(0);
      step();
      stop_req = 1;
      step();
      chk("t4_issue_valid", 32'(ir_valid), 1);
      step();
      stop_req = 0;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_halted", 32'(halted), 0);
      chk("t4_count", 32'(instr_count), 1);
      chk("t4_pc", 32'(pc), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_no_fetch", {imem_rd_en, busy}, 0);
      end
      chk("t4_sb_left", exp_q.size(), 0);
      // async reset while issuing; mid-run start ignored
      ir_ready = 0;
      exp_q.push_back(mem[3]);
      kick(3);
      start_pc = 7;
      start = 1;
      step();
      start = 0;
      step();
      chk("t5_pc_kept", 32'(pc), 3);
      chk("t5_valid", 32'(ir_valid), 1);
      chk("t5_word", ir_out, 32'h2800_0000);
      #2 sys_rst = 1;
      #1;
      chk("t5_rst_valid", 32'(ir_valid), 0);
      chk("t5_rst_pc", 32'(pc), 0);
      chk("t5_rst_count", 32'(instr_count), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      exp_q.delete();
      step();
      sys_rst = 0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
